// File: rtl/seq_acc_alu.sv
// Accumulator ALU with power states; 1-cycle ops, N-cycle shift-add MULT (done pulses the cycle after).
// Back-pressure: op_ready drops during MULT, while OFF, and whenever pwr_off is asserted.
module seq_acc_alu #(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_pwr_on,
    input  logic         i_pwr_off,
    input  logic         i_op_valid,
    output logic         o_op_ready,
    input  logic [3:0]   i_op,
    input  logic [N-1:0] i_in,
    output logic [N-1:0] o_acc_out,
    output logic         o_done,
    output logic         o_carry,
    output logic         o_zero,
    output logic         o_illegal,
    output logic         o_pwr
);

    typedef enum logic [1:0] {S_OFF, S_IDLE, S_MUL} state_t;

    state_t           r_state, w_state_nxt;
    logic [N-1:0]     r_acc;
    logic             r_carry, r_zero, r_illegal, r_done;
    logic [2*N-1:0]   r_mcand, r_prod;
    logic [N-1:0]     r_mplier;
    logic [CNT_W-1:0] r_cnt;

    logic             w_pwr_off, w_accept, w_mul_last;
    logic [N:0]       w_sum;
    logic [2*N-1:0]   w_prod_nxt;
    logic [N-1:0]     w_alu_acc;
    logic             w_alu_carry;

    // pwr_on outranks pwr_off, so both together never powers down
    assign w_pwr_off  = i_pwr_off & ~i_pwr_on;
    assign o_op_ready = (r_state == S_IDLE) & ~i_pwr_off;
    assign w_accept   = i_op_valid & o_op_ready;
    assign w_mul_last = (r_state == S_MUL) && (r_cnt == CNT_W'(N - 1));
    assign w_sum      = {1'b0, r_acc} + {1'b0, i_in};
    assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);

    assign o_acc_out  = (r_state == S_OFF) ? '0 : r_acc;
    assign o_pwr      = (r_state != S_OFF);
    assign o_done     = r_done;
    assign o_carry    = r_carry;
    assign o_zero     = r_zero;
    assign o_illegal  = r_illegal;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_OFF:   if (i_pwr_on) w_state_nxt = S_IDLE;
            S_IDLE: begin
                if (w_pwr_off)                      w_state_nxt = S_OFF;
                else if (w_accept && i_op == 4'd8)  w_state_nxt = S_MUL;
            end
            S_MUL: begin
                if (w_pwr_off)       w_state_nxt = S_OFF;
                else if (w_mul_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_alu_acc   = r_acc;
        w_alu_carry = 1'b0;
        case (i_op)
            4'd1: w_alu_acc = i_in;
            4'd2: w_alu_acc = ~r_acc;
            4'd3: w_alu_acc = r_acc ^ i_in;
            4'd4: w_alu_acc = r_acc | i_in;
            4'd5: w_alu_acc = r_acc & i_in;
            4'd6: begin
                w_alu_acc   = r_acc - i_in;
                w_alu_carry = (r_acc < i_in);
            end
            4'd7: begin
                w_alu_acc   = w_sum[N-1:0];
                w_alu_carry = w_sum[N];
            end
            4'd9: w_alu_acc = '0;
            default: w_alu_acc = r_acc;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_carry   <= 1'b0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
            r_done    <= 1'b0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_prod    <= '0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            if (w_accept) begin
                if (i_op == 4'd8) begin
                    r_mcand  <= {{N{1'b0}}, r_acc};
                    r_mplier <= i_in;
                    r_prod   <= '0;
                    r_cnt    <= '0;
                end else begin
                    r_acc     <= w_alu_acc;
                    r_carry   <= w_alu_carry;
                    r_zero    <= (w_alu_acc == '0);
                    r_illegal <= (i_op >= 4'd10);
                    r_done    <= 1'b1;
                end
            end else if (r_state == S_MUL && !w_pwr_off) begin
                // acc stays untouched until the last step so an abort keeps the old value
                r_prod   <= w_prod_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
                if (w_mul_last) begin
                    r_acc     <= w_prod_nxt[N-1:0];
                    r_carry   <= |w_prod_nxt[2*N-1:N];
                    r_zero    <= (w_prod_nxt[N-1:0] == '0);
                    r_illegal <= 1'b0;
                    r_done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_acc_alu.sv
// Directed bench for seq_acc_alu (N=8) with hand-computed expectations.
module tb_seq_acc_alu;

    logic       clk = 1'b0;
    logic       rst, pwr_on, pwr_off, op_valid;
    logic [3:0] op;
    logic [7:0] din;
    logic       op_ready, done, carry, zero, illegal, pwr;
    logic [7:0] acc_out;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] NOP = 4'd0, LOAD = 4'd1, NOT = 4'd2, XOR = 4'd3, OR = 4'd4,
                           AND = 4'd5, SUB = 4'd6, ADD = 4'd7, MULT = 4'd8, CLR = 4'd9;

    seq_acc_alu #(.N(8), .CNT_W(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_pwr_on(pwr_on), .i_pwr_off(pwr_off),
        .i_op_valid(op_valid), .o_op_ready(op_ready), .i_op(op), .i_in(din),
        .o_acc_out(acc_out), .o_done(done), .o_carry(carry), .o_zero(zero),
        .o_illegal(illegal), .o_pwr(pwr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [7:0] v);
        op_valid = 1'b1; op = o; din = v;
        tick();
        op_valid = 1'b0; op = NOP; din = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if ({acc_out, done, carry, zero, illegal, pwr, op_ready} !== {8'h00, 6'b000011}) begin
            errors++;
            $display("FAIL reset got acc=%h d/c/z/i/p/r=%b%b%b%b%b%b want acc=00 000011",
                     acc_out, done, carry, zero, illegal, pwr, op_ready);
        end
    endtask

    task automatic test_load_add();
        issue(LOAD, 8'h05);
        checks++;
        if ({acc_out, done} !== {8'h05, 1'b1}) begin
            errors++; $display("FAIL load5 got acc=%h done=%b want 05 1", acc_out, done);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL load5_pulse got done=%b want 0", done);
        end
        issue(ADD, 8'h03);
        checks++;
        if ({acc_out, done, carry, zero} !== {8'h08, 3'b100}) begin
            errors++; $display("FAIL add3 got acc=%h d/c/z=%b%b%b want 08 100", acc_out, done, carry, zero);
        end
        tick();
        checks++;
        if ({acc_out, done} !== {8'h08, 1'b0}) begin
            errors++; $display("FAIL add3_pulse got acc=%h done=%b want 08 0", acc_out, done);
        end
    endtask

    task automatic test_flags();
        issue(LOAD, 8'hFF);
        issue(ADD, 8'h01);
        checks++;
        if ({acc_out, carry, zero} !== {8'h00, 2'b11}) begin
            errors++; $display("FAIL add_wrap got acc=%h c/z=%b%b want 00 11", acc_out, carry, zero);
        end
        issue(LOAD, 8'h02);
        checks++;
        if ({acc_out, carry, zero} !== {8'h02, 2'b00}) begin
            errors++; $display("FAIL load_clears_flags got acc=%h c/z=%b%b want 02 00", acc_out, carry, zero);
        end
        issue(SUB, 8'h04);
        checks++;
        if ({acc_out, carry, zero} !== {8'hFE, 2'b10}) begin
            errors++; $display("FAIL sub_borrow got acc=%h c/z=%b%b want fe 10", acc_out, carry, zero);
        end
        issue(SUB, 8'h0E);
        checks++;
        if ({acc_out, carry, zero} !== {8'hF0, 2'b00}) begin
            errors++; $display("FAIL sub_noborrow got acc=%h c/z=%b%b want f0 00", acc_out, carry, zero);
        end
    endtask

    task automatic test_logic();
        issue(LOAD, 8'hA5);
        issue(NOT, 8'h00);
        checks++;
        if (acc_out !== 8'h5A) begin errors++; $display("FAIL not got %h want 5a", acc_out); end
        issue(XOR, 8'hFF);
        checks++;
        if (acc_out !== 8'hA5) begin errors++; $display("FAIL xor got %h want a5", acc_out); end
        issue(OR, 8'h0A);
        checks++;
        if (acc_out !== 8'hAF) begin errors++; $display("FAIL or got %h want af", acc_out); end
        issue(NOP, 8'h11);
        checks++;
        if ({acc_out, done, zero} !== {8'hAF, 2'b10}) begin
            errors++; $display("FAIL nop got acc=%h d/z=%b%b want af 10", acc_out, done, zero);
        end
        issue(CLR, 8'h00);
        checks++;
        if ({acc_out, carry, zero} !== {8'h00, 2'b01}) begin
            errors++; $display("FAIL clr got acc=%h c/z=%b%b want 00 01", acc_out, carry, zero);
        end
    endtask

    task automatic test_mult();
        int busy = 0;
        issue(LOAD, 8'h06);
        op_valid = 1'b1; op = MULT; din = 8'h04;
        tick();
        op = ADD; din = 8'h01;      // held valid during MUL must be ignored
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({op_ready, done, acc_out} !== {2'b00, 8'h06}) begin
                errors++;
                $display("FAIL mul_busy step %0d got rdy=%b done=%b acc=%h want 0 0 06", k, op_ready, done, acc_out);
            end
            if (op_ready === 1'b0) busy++;
            tick();
        end
        checks++;
        if ({acc_out, done, op_ready, carry, zero} !== {8'h18, 4'b1100}) begin
            errors++;
            $display("FAIL mul6x4 got acc=%h d/r/c/z=%b%b%b%b want 18 1100", acc_out, done, op_ready, carry, zero);
        end
        op_valid = 1'b0; op = NOP; din = 8'h00;
        checks++;
        if (busy != 8) begin errors++; $display("FAIL mul_busy_cycles got %0d want 8", busy); end
        tick();
        checks++;
        if ({acc_out, done} !== {8'h18, 1'b0}) begin
            errors++; $display("FAIL mul_done_once got acc=%h done=%b want 18 0", acc_out, done);
        end
        issue(LOAD, 8'h20);
        issue(MULT, 8'h10);
        repeat (7) tick();
        checks++;
        if ({acc_out, done} !== {8'h20, 1'b0}) begin
            errors++; $display("FAIL mul_ovf_early got acc=%h done=%b want 20 0", acc_out, done);
        end
        tick();
        checks++;
        if ({acc_out, done, carry, zero} !== {8'h00, 3'b111}) begin
            errors++; $display("FAIL mul_ovf got acc=%h d/c/z=%b%b%b want 00 111", acc_out, done, carry, zero);
        end
    endtask

    task automatic test_pwr_abort();
        int dones = 0;
        issue(LOAD, 8'h07);
        issue(MULT, 8'h03);
        repeat (3) begin tick(); if (done) dones++; end
        pwr_off = 1'b1;
        tick();
        pwr_off = 1'b0;
        checks++;
        if ({pwr, acc_out, op_ready, done} !== {1'b0, 8'h00, 2'b00}) begin
            errors++;
            $display("FAIL pwr_off got pwr=%b acc=%h rdy=%b done=%b want 0 00 0 0", pwr, acc_out, op_ready, done);
        end
        op_valid = 1'b1; op = ADD; din = 8'h01;
        repeat (10) begin tick(); if (done) dones++; end
        checks++;
        if (op_ready !== 1'b0) begin errors++; $display("FAIL off_ready got %b want 0", op_ready); end
        op_valid = 1'b0; op = NOP; din = 8'h00;
        pwr_on = 1'b1;
        tick();
        pwr_on = 1'b0;
        checks++;
        if ({pwr, acc_out, op_ready, done, carry, zero} !== {1'b1, 8'h07, 4'b1000}) begin
            errors++;
            $display("FAIL pwr_on_retain got pwr=%b acc=%h r/d/c/z=%b%b%b%b want 1 07 1000",
                     pwr, acc_out, op_ready, done, carry, zero);
        end
        checks++;
        if (dones != 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", dones); end
    endtask

    task automatic test_rst_pwr();
        issue(LOAD, 8'h5A);
        rst = 1'b1; pwr_off = 1'b1;
        tick();
        rst = 1'b0; pwr_off = 1'b0;
        checks++;
        if ({pwr, acc_out} !== {1'b1, 8'h00}) begin
            errors++; $display("FAIL rst_over_off got pwr=%b acc=%h want 1 00", pwr, acc_out);
        end
        issue(LOAD, 8'h3C);
        pwr_off = 1'b1;
        tick();
        pwr_off = 1'b0;
        checks++;
        if (pwr !== 1'b0) begin errors++; $display("FAIL go_off got pwr=%b want 0", pwr); end
        pwr_on = 1'b1; pwr_off = 1'b1;
        tick();
        pwr_on = 1'b0; pwr_off = 1'b0;
        checks++;
        if ({pwr, acc_out} !== {1'b1, 8'h3C}) begin
            errors++; $display("FAIL on_and_off got pwr=%b acc=%h want 1 3c", pwr, acc_out);
        end
        issue(LOAD, 8'h03);
        issue(MULT, 8'h05);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({acc_out, done, op_ready, pwr} !== {8'h00, 3'b011}) begin
            errors++; $display("FAIL rst_mid_mul got acc=%h d/r/p=%b%b%b want 00 011", acc_out, done, op_ready, pwr);
        end
        repeat (8) tick();
        checks++;
        if ({acc_out, done} !== {8'h00, 1'b0}) begin
            errors++; $display("FAIL rst_mid_mul_late got acc=%h done=%b want 00 0", acc_out, done);
        end
    endtask

    task automatic test_illegal();
        issue(LOAD, 8'h33);
        issue(4'hC, 8'hAA);
        checks++;
        if ({acc_out, illegal, done, zero} !== {8'h33, 3'b110}) begin
            errors++; $display("FAIL illegal got acc=%h i/d/z=%b%b%b want 33 110", acc_out, illegal, done, zero);
        end
        issue(AND, 8'h0F);
        checks++;
        if ({acc_out, illegal, done} !== {8'h03, 2'b01}) begin
            errors++; $display("FAIL and_after_illegal got acc=%h i/d=%b%b want 03 01", acc_out, illegal, done);
        end
    endtask

    initial begin
        rst = 1'b1; pwr_on = 1'b0; pwr_off = 1'b0; op_valid = 1'b0; op = NOP; din = 8'h00;
        test_reset();
        test_load_add();
        test_flags();
        test_logic();
        test_mult();
        test_pwr_abort();
        test_rst_pwr();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
